simon_iterative_core: RTL and testbench
=======================================

SIMON_ITERATIVE_CORE -- requirements
Module: simon_iterative_core

Interface
REQ-001 Parameter WORD_W, default 16, SIMON word size n in bits; block width is 2*WORD_W.
REQ-002 Parameter KEY_WORDS, default 4, SIMON key words m; key width is KEY_WORDS*WORD_W.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 key_valid  input  1  key offer.
REQ-006 key_ready  output  1  core accepts key this cycle.
REQ-007 key  input  KEY_WORDS*WORD_W  master key; word k[0] in LSBs, k[m-1] in MSBs.
REQ-008 key_loaded  output  1  round-key buffer holds a complete expanded key.
REQ-009 in_valid  input  1  block offer.
REQ-010 in_ready  output  1  core accepts block this cycle.
REQ-011 in_decrypt  input  1  0 = encrypt, 1 = decrypt; sampled with the block.
REQ-012 in_block  input  2*WORD_W  x word in upper half, y word in lower half.
REQ-013 out_valid  output  1  result available.
REQ-014 out_ready  input  1  downstream accepts result.
REQ-015 out_block  output  2*WORD_W  result, same x/y packing as in_block.

Function
REQ-016 Supported (WORD_W, KEY_WORDS) pairs: (16,4), (24,3), (24,4), (32,3), (32,4); any other pair is an elaboration error.
REQ-017 Round count T and z-sequence index: 32/z0, 36/z0, 36/z1, 42/z2, 44/z3 for the pairs in REQ-016 order; constants c and z0..z3 per the SIMON definition.
REQ-018 FSM states: IDLE, KEYEXP, READY, RUN, HOLD.
REQ-019 Handshakes complete on a rising edge where valid and ready are both high; valid/ready are independent (ready does not wait for valid).
REQ-020 key_ready high in IDLE and READY only; key accepted -> KEYEXP, key_loaded cleared the same edge.
REQ-021 KEYEXP: one round key written per cycle into a T-entry buffer; entries 0..m-1 are the master key words, entries m..T-1 use the standard SIMON key recurrence for m=3 or m=4; KEYEXP lasts exactly T cycles, then READY with key_loaded=1.
REQ-022 in_ready high only in READY; block accepted -> RUN with round index 0 (encrypt) or T-1 (decrypt).
REQ-023 Round function f(x) = (x<<<1 & x<<<8) ^ (x<<<2), rotations modulo WORD_W.
REQ-024 Encrypt round i: x' = y ^ f(x) ^ k[i], y' = x; index increments 0..T-1.
REQ-025 Decrypt round i: x' = y, y' = x ^ f(y) ^ k[i]; index decrements T-1..0.
REQ-026 RUN performs one round per cycle for exactly T cycles, then HOLD; out_valid asserts on the edge completing round T, i.e. T+1 edges after the accept edge.
REQ-027 HOLD: out_valid and out_block stable until out_ready; handshake edge -> READY, so a new block is accepted no earlier than the cycle after.
REQ-028 key_valid during KEYEXP, RUN or HOLD is ignored (key_ready low); the round-key buffer is never written during RUN or HOLD.
REQ-029 in_valid while key_loaded=0 is never accepted; in_valid and key_valid both high in READY: key takes priority, block not accepted.
REQ-030 in_decrypt and in_block ignored outside the accept edge.

Reset
REQ-031 rst high forces IDLE, key_loaded=0, key_ready=0 while rst held, in_ready=0, out_valid=0, out_block=0, round index 0, immediately and independent of clk.
REQ-032 rst mid-KEYEXP or mid-RUN aborts; no partial result is ever presented; a new key is required after reset.
REQ-033 Round-key buffer contents need not be reset; key_loaded=0 makes them unused.

Verification
REQ-034 (16,4): key 0x1918111009080100, encrypt 0x65656877 -> out_block 0xc69be9bb, out_valid exactly 33 edges after accept.
REQ-035 (16,4): same key, decrypt 0xc69be9bb -> 0x65656877; then 20 random encrypt/decrypt round-trips all restore plaintext.
REQ-036 (32,4): key 0x1b1a1918131211100b0a090803020100, encrypt 0x656b696c20646e75 -> 0x44c8fc20b9dfa07a after 45 edges.
REQ-037 Backpressure: out_ready low 10 cycles in HOLD -> out_block stable, in_ready low, key_ready low; in_valid and key_valid offered during RUN -> neither accepted.
REQ-038 in_valid before any key -> in_ready stays 0; rst asserted at round 5 of RUN -> all outputs 0 immediately, key_loaded 0, no out_valid after release until rekey and new block.

Source files
------------

// File: rtl/simon_iterative_core.sv
// SIMON block cipher core: one round per clock, round keys expanded once into
// a local buffer and reused for every block until a new key is loaded.
//
// state  | meaning
// IDLE   | no expanded key, waiting for a key
// KEYEXP | writing one round key per cycle into the buffer
// READY  | key loaded, waiting for a block (a new key may also be offered)
// RUN    | one encrypt or decrypt round per cycle
// HOLD   | result presented until downstream takes it
module simon_iterative_core #(
    parameter int WORD_W    = 16,
    parameter int KEY_WORDS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          key_valid,
    output logic                          key_ready,
    input  logic [KEY_WORDS*WORD_W-1:0]   key,
    output logic                          key_loaded,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_decrypt,
    input  logic [2*WORD_W-1:0]           in_block,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [2*WORD_W-1:0]           out_block
);

    localparam bit SUPPORTED =
        (WORD_W == 16 && KEY_WORDS == 4) || (WORD_W == 24 && KEY_WORDS == 3) ||
        (WORD_W == 24 && KEY_WORDS == 4) || (WORD_W == 32 && KEY_WORDS == 3) ||
        (WORD_W == 32 && KEY_WORDS == 4);

    localparam int ROUNDS =
        (WORD_W == 24)                    ? 36 :
        (WORD_W == 32 && KEY_WORDS == 3)  ? 42 :
        (WORD_W == 32 && KEY_WORDS == 4)  ? 44 : 32;

    localparam int ZSEL =
        (WORD_W == 24 && KEY_WORDS == 4)  ? 1 :
        (WORD_W == 32 && KEY_WORDS == 3)  ? 2 :
        (WORD_W == 32 && KEY_WORDS == 4)  ? 3 : 0;

    localparam int IDX_W = (ROUNDS > 32) ? 6 : 5;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(ROUNDS - 1);

    if (!SUPPORTED) begin : g_bad_params
        $error("simon_iterative_core: unsupported (WORD_W, KEY_WORDS) pair");
    end

    // z sequences written in the published order; bit j of the result is z_j
    function automatic logic [61:0] z_rev(input int sel);
        logic [61:0] z;
        logic [61:0] r;
        case (sel)
            0:       z = 62'b11111010001001010110000111001101111101000100101011000011100110;
            1:       z = 62'b10001110111110010011000010110101000111011111001001100001011010;
            2:       z = 62'b10101111011100000011010010011000101000010001111110010110110011;
            default: z = 62'b11011011101011000110010111100000010010001010011100110100001111;
        endcase
        for (int j = 0; j < 62; j++) r[j] = z[61-j];
        return r;
    endfunction

    localparam logic [61:0] Z_BITS = z_rev(ZSEL);

    function automatic logic [WORD_W-1:0] rotl(input logic [WORD_W-1:0] v, input int s);
        return (v << s) | (v >> (WORD_W - s));
    endfunction

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] v, input int s);
        return (v >> s) | (v << (WORD_W - s));
    endfunction

    function automatic logic [WORD_W-1:0] simon_f(input logic [WORD_W-1:0] v);
        return (rotl(v, 1) & rotl(v, 8)) ^ rotl(v, 2);
    endfunction

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_KEYEXP = 3'd1;
    localparam logic [2:0] S_READY  = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_HOLD   = 3'd4;

    logic [2:0]        r_state;
    logic [IDX_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic              r_key_loaded;
    logic              r_dec;
    logic [WORD_W-1:0] r_x;
    logic [WORD_W-1:0] r_y;
    logic [WORD_W-1:0] r_ks [KEY_WORDS];
    logic [WORD_W-1:0] r_rk [ROUNDS];

    logic              w_key_fire;
    logic              w_in_fire;
    logic              w_out_fire;
    logic [WORD_W-1:0] w_rk;
    logic [WORD_W-1:0] w_enc_x;
    logic [WORD_W-1:0] w_dec_y;
    logic [WORD_W-1:0] w_ks_tmp;
    logic [WORD_W-1:0] w_ks_new;
    logic [5:0]        w_zidx;

    // key_ready is gated by rst so the IDLE decode cannot leak out during reset;
    // a pending key always wins over a pending block in READY
    assign key_ready  = !rst && (r_state == S_IDLE || r_state == S_READY);
    assign in_ready   = (r_state == S_READY) && !key_valid;
    assign out_valid  = (r_state == S_HOLD);
    assign key_loaded = r_key_loaded;
    assign out_block  = {r_x, r_y};

    assign w_key_fire = key_valid && key_ready;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;

    assign w_rk    = r_rk[r_idx];
    assign w_enc_x = r_y ^ simon_f(r_x) ^ w_rk;
    assign w_dec_y = r_x ^ simon_f(r_y) ^ w_rk;
    assign w_zidx  = 6'(r_idx);

    // next key word from the window k[i-m..i-1] held in r_ks[0..m-1]
    always_comb begin
        w_ks_tmp = rotr(r_ks[KEY_WORDS-1], 3);
        if (KEY_WORDS == 4) w_ks_tmp = w_ks_tmp ^ r_ks[1];
        w_ks_tmp = w_ks_tmp ^ rotr(w_ks_tmp, 1);
        w_ks_new = ~r_ks[0] ^ w_ks_tmp ^ WORD_W'(3) ^ WORD_W'(Z_BITS[w_zidx]);
    end

    // key window shift and round-key buffer writes; contents are don't-care until key_loaded
    always_ff @(posedge clk) begin
        if (w_key_fire) begin
            for (int j = 0; j < KEY_WORDS; j++) r_ks[j] <= key[j*WORD_W +: WORD_W];
        end else if (r_state == S_KEYEXP) begin
            for (int j = 0; j < KEY_WORDS - 1; j++) r_ks[j] <= r_ks[j+1];
            r_ks[KEY_WORDS-1] <= w_ks_new;
            r_rk[r_idx]       <= r_ks[0];
        end
    end

    // control FSM with down-counter timing for key expansion and rounds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_key_loaded <= 1'b0;
            r_dec        <= 1'b0;
            r_x          <= '0;
            r_y          <= '0;
        end else if (w_key_fire) begin
            r_state      <= S_KEYEXP;
            r_cnt        <= LAST;
            r_idx        <= '0;
            r_key_loaded <= 1'b0;
        end else begin
            case (r_state)
                S_KEYEXP: begin
                    r_idx <= r_idx + IDX_W'(1);
                    if (r_cnt == '0) begin
                        r_state      <= S_READY;
                        r_key_loaded <= 1'b1;
                        r_idx        <= '0;
                    end else begin
                        r_cnt <= r_cnt - IDX_W'(1);
                    end
                end
                S_READY: begin
                    if (w_in_fire) begin
                        r_state <= S_RUN;
                        r_dec   <= in_decrypt;
                        r_x     <= in_block[2*WORD_W-1:WORD_W];
                        r_y     <= in_block[WORD_W-1:0];
                        r_idx   <= in_decrypt ? LAST : '0;
                        r_cnt   <= LAST;
                    end
                end
                S_RUN: begin
                    if (r_dec) begin
                        r_x   <= r_y;
                        r_y   <= w_dec_y;
                        r_idx <= r_idx - IDX_W'(1);
                    end else begin
                        r_x   <= w_enc_x;
                        r_y   <= r_x;
                        r_idx <= r_idx + IDX_W'(1);
                    end
                    if (r_cnt == '0) begin
                        r_state <= S_HOLD;
                        r_idx   <= '0;
                    end else begin
                        r_cnt <= r_cnt - IDX_W'(1);
                    end
                end
                S_HOLD: begin
                    if (w_out_fire) r_state <= S_READY;
                end
                S_IDLE: ;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_simon_iterative_core.sv
// Bench for simon_iterative_core: SIMON 32/64 instance driven through a
// scoreboard, plus a SIMON 64/128 instance for its known-answer vector.
module tb_simon_iterative_core;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        a_key_valid, a_key_ready, a_key_loaded;
    logic [63:0] a_key;
    logic        a_in_valid, a_in_ready, a_in_decrypt;
    logic [31:0] a_in_block;
    logic        a_out_valid, a_out_ready;
    logic [31:0] a_out_block;

    logic         b_key_valid, b_key_ready, b_key_loaded;
    logic [127:0] b_key;
    logic         b_in_valid, b_in_ready, b_in_decrypt;
    logic [63:0]  b_in_block;
    logic         b_out_valid, b_out_ready;
    logic [63:0]  b_out_block;

    simon_iterative_core #(.WORD_W(16), .KEY_WORDS(4)) dut_a (
        .clk(clk), .rst(rst),
        .key_valid(a_key_valid), .key_ready(a_key_ready), .key(a_key), .key_loaded(a_key_loaded),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_decrypt(a_in_decrypt), .in_block(a_in_block),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_block(a_out_block)
    );

    simon_iterative_core #(.WORD_W(32), .KEY_WORDS(4)) dut_b (
        .clk(clk), .rst(rst),
        .key_valid(b_key_valid), .key_ready(b_key_ready), .key(b_key), .key_loaded(b_key_loaded),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_decrypt(b_in_decrypt), .in_block(b_in_block),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_block(b_out_block)
    );

    localparam logic [63:0] KEY_A = 64'h1918111009080100;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] a_sb [$];
    logic [31:0] a_last;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rol(input logic [63:0] v, input int s, input int w);
        logic [63:0] m;
        m = (64'd1 << w) - 64'd1;
        return ((v << s) | (v >> (w - s))) & m;
    endfunction

    function automatic logic [63:0] rf(input logic [63:0] v, input int w);
        return (rol(v, 1, w) & rol(v, 8, w)) ^ rol(v, 2, w);
    endfunction

    // reference SIMON written from the published definition
    function automatic logic [63:0] simon_ref(input int w, input int m, input int t, input int zs,
                                              input logic [127:0] k, input logic [63:0] b, input bit dec);
        logic [63:0] mask, x, y, tmp;
        logic [63:0] rk [44];
        logic [61:0] z;
        mask = (64'd1 << w) - 64'd1;
        case (zs)
            0:       z = 62'b11111010001001010110000111001101111101000100101011000011100110;
            1:       z = 62'b10001110111110010011000010110101000111011111001001100001011010;
            2:       z = 62'b10101111011100000011010010011000101000010001111110010110110011;
            default: z = 62'b11011011101011000110010111100000010010001010011100110100001111;
        endcase
        for (int i = 0; i < m; i++) rk[i] = 64'(k >> (i*w)) & mask;
        for (int i = m; i < t; i++) begin
            tmp = rol(rk[i-1], w - 3, w);
            if (m == 4) tmp = tmp ^ rk[i-3];
            tmp = tmp ^ rol(tmp, w - 1, w);
            rk[i] = (~rk[i-m] & mask) ^ tmp ^ 64'(z[61-(i-m)]) ^ 64'd3;
        end
        x = (b >> w) & mask;
        y = b & mask;
        if (!dec) begin
            for (int i = 0; i < t; i++) begin
                tmp = x; x = y ^ rf(x, w) ^ rk[i]; y = tmp;
            end
        end else begin
            for (int i = t - 1; i >= 0; i--) begin
                tmp = y; y = x ^ rf(y, w) ^ rk[i]; x = tmp;
            end
        end
        return (x << w) | y;
    endfunction

    function automatic logic [31:0] ref_a(input logic [31:0] b, input bit dec);
        return 32'(simon_ref(16, 4, 32, 0, {64'd0, KEY_A}, {32'd0, b}, dec));
    endfunction

    // result monitor: every out handshake on dut_a pops one expectation
    always @(negedge clk) begin
        if (!rst && a_out_valid && a_out_ready) begin
            a_last = a_out_block;
            if (a_sb.size() == 0) chk("a_unexpected_out", 64'd1, 64'd0);
            else chk("a_out_block", {32'd0, a_out_block}, {32'd0, a_sb.pop_front()});
        end
    end

    task automatic a_load_key(input logic [63:0] k, output int n);
        bit acc;
        acc = 1'b0;
        a_key = k;
        a_key_valid = 1'b1;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk); acc = a_key_ready;
            @(posedge clk); #1;
        end
        a_key_valid = 1'b0;
        if (!acc) chk("a_key_accept_timeout", 64'd0, 64'd1);
        chk("a_keyexp_key_ready", {63'd0, a_key_ready}, 64'd0);
        n = 0;
        while (!a_key_loaded && n < 200) begin
            @(posedge clk); #1; n++;
        end
    endtask

    task automatic a_offer(input logic [31:0] blk, input bit dec, input logic [31:0] exp);
        bit acc;
        acc = 1'b0;
        a_in_block = blk;
        a_in_decrypt = dec;
        a_in_valid = 1'b1;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk); acc = a_in_ready;
            @(posedge clk); #1;
        end
        a_in_valid = 1'b0;
        a_in_block = $urandom;
        a_in_decrypt = ~dec;
        if (acc) a_sb.push_back(exp);
        else chk("a_in_accept_timeout", 64'd0, 64'd1);
    endtask

    // counts edges from the accept edge (inclusive) to the edge raising out_valid
    task automatic a_wait_out(output int lat);
        lat = 1;
        while (!a_out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic a_drain();
        for (int i = 0; i < 100 && a_sb.size() != 0; i++) @(posedge clk);
        #1;
        chk("a_drain", 64'(a_sb.size()), 64'd0);
    endtask

    int          n, lat;
    bit          bad, bad2;
    logic [31:0] p, c, hold_val;

    initial begin
        rst = 1'b1;
        a_key_valid = 1'b1; a_key = KEY_A; a_in_valid = 1'b0; a_in_decrypt = 1'b0;
        a_in_block = '0; a_out_ready = 1'b1;
        b_key_valid = 1'b0; b_key = '0; b_in_valid = 1'b0; b_in_decrypt = 1'b0;
        b_in_block = '0; b_out_ready = 1'b1;
        #2;
        chk("rst_outputs_a", {a_key_ready, a_in_ready, a_out_valid, a_key_loaded, a_out_block}, 64'd0);
        chk("rst_outputs_b", {b_key_ready, b_in_ready, b_out_valid, b_key_loaded}, 64'd0);
        a_key_valid = 1'b0;
        a_in_valid = 1'b1;
        #20 rst = 1'b0;

        // block offered before any key
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (a_in_ready || a_out_valid) bad = 1'b1;
        end
        chk("a_no_key_no_accept", {63'd0, bad}, 64'd0);
        a_in_valid = 1'b0;
        @(posedge clk); #1;

        a_load_key(KEY_A, n);
        chk("a_keyexp_cycles", 64'(n), 64'd32);
        chk("a_ready_after_key", {62'd0, a_key_loaded, a_in_ready}, 64'd3);

        a_offer(32'h65656877, 1'b0, 32'hc69be9bb);
        a_wait_out(lat);
        chk("a_enc_latency", 64'(lat), 64'd33);
        a_drain();

        a_offer(32'hc69be9bb, 1'b1, 32'h65656877);
        a_wait_out(lat);
        chk("a_dec_latency", 64'(lat), 64'd33);
        a_drain();

        for (int r = 0; r < 20; r++) begin
            bit first_dec;
            p = $urandom;
            first_dec = 1'($urandom_range(0, 1));
            a_offer(p, first_dec, ref_a(p, first_dec));
            a_drain();
            a_offer(a_last, ~first_dec, p);
            a_drain();
        end

        // backpressure: offers during RUN and a 10-cycle stall in HOLD
        a_out_ready = 1'b0;
        p = $urandom;
        a_offer(p, 1'b0, ref_a(p, 1'b0));
        a_in_valid = 1'b1; a_in_block = $urandom;
        a_key_valid = 1'b1; a_key = 64'h0123456789abcdef;
        bad = 1'b0;
        for (int i = 0; i < 100 && !a_out_valid; i++) begin
            @(negedge clk);
            if (a_in_ready || a_key_ready) bad = 1'b1;
        end
        chk("a_run_no_accept", {63'd0, bad}, 64'd0);
        chk("a_hold_reached", {63'd0, a_out_valid}, 64'd1);
        hold_val = a_out_block;
        bad2 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (a_out_block !== hold_val || a_in_ready || a_key_ready || !a_out_valid) bad2 = 1'b1;
        end
        chk("a_hold_stable", {63'd0, bad2}, 64'd0);
        chk("a_hold_key_loaded", {63'd0, a_key_loaded}, 64'd1);
        a_in_valid = 1'b0; a_key_valid = 1'b0; a_key = KEY_A;
        @(posedge clk); #1;
        a_out_ready = 1'b1;
        a_drain();

        // key and block offered together in READY: key wins
        a_in_valid = 1'b1; a_in_block = $urandom; a_key_valid = 1'b1;
        @(negedge clk);
        chk("a_prio_in_ready", {63'd0, a_in_ready}, 64'd0);
        chk("a_prio_key_ready", {63'd0, a_key_ready}, 64'd1);
        @(posedge clk); #1;
        a_in_valid = 1'b0; a_key_valid = 1'b0;
        chk("a_prio_key_loaded_cleared", {63'd0, a_key_loaded}, 64'd0);
        n = 0;
        while (!a_key_loaded && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk("a_rekey_cycles", 64'(n), 64'd32);
        p = $urandom;
        a_offer(p, 1'b0, ref_a(p, 1'b0));
        a_drain();

        // reset at round 5 of RUN
        p = $urandom;
        a_offer(p, 1'b0, ref_a(p, 1'b0));
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("a_rst_mid_run_outputs", {a_key_ready, a_in_ready, a_out_valid, a_key_loaded, a_out_block}, 64'd0);
        a_sb.delete();
        #10 rst = 1'b0;
        a_in_valid = 1'b1; a_in_block = $urandom;
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (a_in_ready || a_out_valid || a_key_loaded) bad = 1'b1;
        end
        chk("a_after_rst_idle", {63'd0, bad}, 64'd0);
        a_in_valid = 1'b0;
        @(posedge clk); #1;
        a_load_key(KEY_A, n);
        chk("a_keyexp_cycles_after_rst", 64'(n), 64'd32);
        a_offer(32'h65656877, 1'b0, 32'hc69be9bb);
        a_wait_out(lat);
        chk("a_enc_latency_after_rst", 64'(lat), 64'd33);
        a_drain();

        // 64/128 instance known-answer vector and its inverse
        begin
            bit acc;
            b_key = 128'h1b1a1918131211100b0a090803020100;
            b_key_valid = 1'b1; acc = 1'b0;
            for (int i = 0; i < 100 && !acc; i++) begin
                @(negedge clk); acc = b_key_ready;
                @(posedge clk); #1;
            end
            b_key_valid = 1'b0;
            n = 0;
            while (!b_key_loaded && n < 200) begin
                @(posedge clk); #1; n++;
            end
            chk("b_keyexp_cycles", 64'(n), 64'd44);
            for (int d = 0; d < 2; d++) begin
                b_in_block = (d == 0) ? 64'h656b696c20646e75 : 64'h44c8fc20b9dfa07a;
                b_in_decrypt = 1'(d);
                b_in_valid = 1'b1; acc = 1'b0;
                for (int i = 0; i < 100 && !acc; i++) begin
                    @(negedge clk); acc = b_in_ready;
                    @(posedge clk); #1;
                end
                b_in_valid = 1'b0;
                b_in_block = '0;
                lat = 1;
                while (!b_out_valid && lat < 100) begin
                    @(posedge clk); #1; lat++;
                end
                chk("b_latency", 64'(lat), 64'd45);
                chk("b_kat", b_out_block, (d == 0) ? 64'h44c8fc20b9dfa07a : 64'h656b696c20646e75);
                @(posedge clk); #1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
